// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a single-cycle
// one-hot write into a shared register bank, then acknowledges the winner.
//
// state | meaning
// IDLE  | waiting for any req; grant and latch winner at the edge
// WRITE | reg_en one-hot(lat_addr), reg_d = lat_data for one cycle
// ACK   | ack one-hot(win) for one cycle; ptr advances past winner
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic [NREG-1:0]    reg_en,
  output logic [DW-1:0]      reg_d,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] pick;
  logic          grant;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_data;

  // First requester at or after p, wrapping at NREQ (which need not be a power of 2).
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   p);
    logic found;
    int   idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(p) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && r[idx]) begin
        found   = 1'b1;
        rr_pick = PW'(idx);
      end
    end
  endfunction

  assign pick = rr_pick(req, ptr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant     = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      win      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      if (grant) begin
        win      <= pick;
        lat_addr <= req_addr[int'(pick)*AW +: AW];
        lat_data <= req_data[int'(pick)*DW +: DW];
      end
      if (state == ACK) begin
        ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  // Outputs decode registered state only, so reset clears them without a clock.
  assign reg_en = (state == WRITE) ? (NREG'(1) << lat_addr) : '0;
  assign ack    = (state == ACK)   ? (NREQ'(1) << win)      : '0;
  assign reg_d  = lat_data;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: hand-computed expectations for grant
// order, write timing, data latching, and asynchronous reset.
module tb_reg_write_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int AW   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [NREG-1:0]    reg_en;
  logic [DW-1:0]      reg_d;
  logic               busy;

  logic [DW-1:0] bank [NREG];
  int  checks   = 0;
  int  failures = 0;
  bit  mon_on   = 1'b0;

  reg_write_arbiter #(.NREQ(NREQ), .DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .req_data(req_data), .ack(ack), .reg_en(reg_en), .reg_d(reg_d),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Register bank model fed only by the arbiter outputs.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) if (reg_en[i]) bank[i] <= reg_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on)
      chk("onehot_excl", {29'd0, $onehot0(reg_en), $onehot0(ack), !((|reg_en) && (|ack))}, 32'd7);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  int exp_w;

  initial begin
    reset = 1'b1; req = '0; req_addr = '0; req_data = '0;
    #1;
    chk("rst_reg_en", reg_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_reg_d", reg_d, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_on = 1'b1;
    tick();

    // Single request from requester 1 to register 3
    set_req(1, 2'd3, 8'hA5);
    req = 4'b0010;
    tick();
    chk("single_en", reg_en, 4'b1000);
    chk("single_d", reg_d, 8'hA5);
    chk("single_busy_w", busy, 1);
    chk("single_ack_w", ack, 0);
    tick();
    chk("single_ack", ack, 4'b0010);
    chk("single_en_a", reg_en, 0);
    chk("single_busy_a", busy, 1);
    chk("single_bank", bank[3], 8'hA5);
    req = '0;
    tick();
    chk("single_busy_i", busy, 0);
    chk("single_ack_i", ack, 0);

    // Reset in the middle of a WRITE cycle (ptr is 2 before this)
    set_req(0, 2'd2, 8'h5C);
    req = 4'b0001;
    tick();
    chk("rstw_en_pre", reg_en, 4'b0100);
    req = '0;
    #1 reset = 1'b1;
    #1;
    chk("rstw_en", reg_en, 0);
    chk("rstw_ack", ack, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_d", reg_d, 0);
    #1 reset = 1'b0;
    tick();
    chk("rstw_bank2", bank[2], 0);

    // Simultaneous requests 1 and 3; ptr back at 0 so 1 wins first
    set_req(1, 2'd1, 8'h31);
    set_req(3, 2'd0, 8'h73);
    req = 4'b1010;
    tick();
    chk("sim1_en", reg_en, 4'b0010);
    chk("sim1_d", reg_d, 8'h31);
    tick();
    chk("sim1_ack", ack, 4'b0010);
    req = 4'b1000;
    tick();
    chk("sim_idle", busy, 0);
    tick();
    chk("sim3_en", reg_en, 4'b0001);
    chk("sim3_d", reg_d, 8'h73);
    tick();
    chk("sim3_ack", ack, 4'b1000);
    req = '0;
    tick();

    // Saturation: grants rotate 0,1,2,3 from ptr 0
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), DW'(8'h40 + i));
    req = 4'b1111;
    for (int t = 0; t < 12; t++) begin
      exp_w = t % NREQ;
      tick();
      chk("sat_en", reg_en, 32'(1) << exp_w);
      chk("sat_d", reg_d, 8'h40 + exp_w);
      tick();
      chk("sat_ack", ack, 32'(1) << exp_w);
      tick();
      chk("sat_idle_ack", ack, 0);
      if (t == 11) req = '0;
    end
    chk("sat_bank3", bank[3], 8'h43);

    // Data change after grant does not reach the bank (ptr now 0)
    set_req(0, 2'd2, 8'h11);
    req = 4'b0001;
    tick();
    set_req(0, 2'd2, 8'h22);
    chk("dchg_en", reg_en, 4'b0100);
    chk("dchg_d_w", reg_d, 8'h11);
    tick();
    chk("dchg_ack", ack, 4'b0001);
    chk("dchg_d_a", reg_d, 8'h11);
    chk("dchg_bank", bank[2], 8'h11);
    req = '0;
    tick();

    // Late request from 2 during WRITE of 0; 0 dropped during ACK (ptr is 1)
    set_req(0, 2'd3, 8'h0F);
    req = 4'b0001;
    tick();
    set_req(2, 2'd1, 8'h99);
    req = 4'b0101;
    chk("late_en0", reg_en, 4'b1000);
    tick();
    chk("late_ack0", ack, 4'b0001);
    req = 4'b0100;
    tick();
    chk("late_idle", busy, 0);
    tick();
    chk("late_en2", reg_en, 4'b0010);
    chk("late_d2", reg_d, 8'h99);
    tick();
    chk("late_ack2", ack, 4'b0100);
    req = '0;
    tick();
    tick();
    chk("late_norepeat_en", reg_en, 0);
    chk("late_norepeat_busy", busy, 0);
    chk("late_bank3", bank[3], 8'h0F);
    chk("late_bank1", bank[1], 8'h99);

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
